// File: rtl/alu_decoder_mc.sv
// ALU control decoder with multi-cycle MULT/DIV sequencing: decodes ALUOp/Funct
// into a 4-bit ALU code and stalls the pipeline while the mul/div unit works.
module alu_decoder_mc #(
    parameter int Funct_size = 6,
    parameter int Ctrl_size  = 4,
    parameter int MulLatency = 4,
    parameter int DivLatency = 32,
    parameter int Cnt_size   = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Funct_size-1:0] Funct,
    input  logic [1:0]            ALUOp,
    input  logic                  InstrValid,
    output logic [Ctrl_size-1:0]  ALUControl,
    output logic                  IllegalFunct,
    output logic                  MDStart,
    output logic                  MDOp,
    output logic                  Stall,
    output logic                  HiLoWrite
);

    localparam logic [Funct_size-1:0] F_ADD  = Funct_size'(6'b100000);
    localparam logic [Funct_size-1:0] F_SUB  = Funct_size'(6'b100010);
    localparam logic [Funct_size-1:0] F_AND  = Funct_size'(6'b100100);
    localparam logic [Funct_size-1:0] F_OR   = Funct_size'(6'b100101);
    localparam logic [Funct_size-1:0] F_NOR  = Funct_size'(6'b100111);
    localparam logic [Funct_size-1:0] F_SLT  = Funct_size'(6'b101010);
    localparam logic [Funct_size-1:0] F_MUL  = Funct_size'(6'b011100);
    localparam logic [Funct_size-1:0] F_MULT = Funct_size'(6'b011000);
    localparam logic [Funct_size-1:0] F_DIV  = Funct_size'(6'b011010);

    localparam logic [Cnt_size-1:0] MUL_INIT = Cnt_size'(MulLatency - 1);
    localparam logic [Cnt_size-1:0] DIV_INIT = Cnt_size'(DivLatency - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [Cnt_size-1:0] cnt, cnt_next;
    logic                md_op, md_op_next;
    logic [3:0]          code;
    logic                is_mult, is_div, start;

    assign is_mult = (Funct == F_MULT);
    assign is_div  = (Funct == F_DIV);
    assign start   = (state == IDLE) && InstrValid && (ALUOp == 2'b10) && (is_mult || is_div);

    // Decode is purely combinational and independent of the sequencer and RST.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        code         = 4'b0010;
        IllegalFunct = 1'b0;
        case (ALUOp)
            2'b01: code = 4'b0100;
            2'b10: begin
                case (Funct)
                    F_ADD:   code = 4'b0010;
                    F_SUB:   code = 4'b0100;
                    F_AND:   code = 4'b0000;
                    F_OR:    code = 4'b0001;
                    F_NOR:   code = 4'b1000;
                    F_SLT:   code = 4'b0110;
                    F_MUL:   code = 4'b0101;
                    F_MULT:  code = 4'b0011;
                    F_DIV:   code = 4'b0111;
                    default: IllegalFunct = InstrValid;
                endcase
            end
            default: code = 4'b0010;
        endcase
    end

    assign ALUControl = Ctrl_size'(code);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_op_next = md_op;
        MDStart    = 1'b0;
        Stall      = 1'b0;
        HiLoWrite  = 1'b0;
        MDOp       = md_op;
        case (state)
            IDLE: begin
                if (start) begin
                    MDStart    = 1'b1;
                    Stall      = 1'b1;
                    MDOp       = is_div;
                    md_op_next = is_div;
                    cnt_next   = is_div ? DIV_INIT : MUL_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - Cnt_size'(1);
            end
            DONE: begin
                // The stalled MULT/DIV is still on the inputs here; never restart from DONE.
                HiLoWrite  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (RST) begin
            MDStart   = 1'b0;
            Stall     = 1'b0;
            HiLoWrite = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so each register samples pre-edge values.
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            md_op <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            md_op <= md_op_next;
        end
    end

endmodule

// File: tb/tb_alu_decoder_mc.sv
// Self-checking bench for alu_decoder_mc: directed scenarios plus randomized
// traffic, compared against a cycle-level transaction model of the decoder.
module tb_alu_decoder_mc;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_BAD  = 6'b111111;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Funct = '0;
    logic [1:0] ALUOp = '0;
    logic       InstrValid = 1'b0;
    logic [3:0] ALUControl;
    logic       IllegalFunct, MDStart, MDOp, Stall, HiLoWrite;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    alu_decoder_mc #(
        .Funct_size(6), .Ctrl_size(4), .MulLatency(MUL_LAT), .DivLatency(DIV_LAT), .Cnt_size(6)
    ) dut (
        .CLK(CLK), .RST(RST), .Funct(Funct), .ALUOp(ALUOp), .InstrValid(InstrValid),
        .ALUControl(ALUControl), .IllegalFunct(IllegalFunct), .MDStart(MDStart),
        .MDOp(MDOp), .Stall(Stall), .HiLoWrite(HiLoWrite)
    );

    // Funct -> ALU code table for ALUOp=10.
    logic [5:0] funct_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                  6'b101010, 6'b011100, 6'b011000, 6'b011010};
    logic [3:0] code_tab  [9] = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b1000,
                                  4'b0110, 4'b0101, 4'b0011, 4'b0111};

    // Model: remaining stall cycles of the running op, and a pending HI/LO write.
    int   busy_left = 0;
    bit   hw_due    = 0;
    bit   op_q      = 0;
    logic exp_start, exp_stall, exp_hw, exp_op, exp_ill;
    logic [3:0] exp_code;

    task automatic model_step(input logic [5:0] f, input logic [1:0] a, input logic v, input logic r);
        bit known = 0;
        exp_code = 4'b0010;
        exp_ill  = 1'b0;
        if (a == 2'b01) exp_code = 4'b0100;
        if (a == 2'b10) begin
            for (int i = 0; i < 9; i++) begin
                if (f == funct_tab[i]) begin
                    exp_code = code_tab[i];
                    known    = 1;
                end
            end
            exp_ill = v && !known;
        end
        exp_start = 1'b0;
        exp_stall = 1'b0;
        exp_hw    = 1'b0;
        if (r) begin
            busy_left = 0;
            hw_due    = 0;
            op_q      = 0;
        end else if (busy_left > 0) begin
            exp_stall = 1'b1;
            busy_left--;
            if (busy_left == 0) hw_due = 1;
        end else if (hw_due) begin
            exp_hw = 1'b1;
            hw_due = 0;
        end else if (v && a == 2'b10 && (f == F_MULT || f == F_DIV)) begin
            exp_start = 1'b1;
            exp_stall = 1'b1;
            op_q      = (f == F_DIV);
            busy_left = op_q ? DIV_LAT : MUL_LAT;
        end
        exp_op = op_q;
    endtask

    // One clock cycle: drive just after the rising edge, settle until the falling edge.
    task automatic cycle(input logic [5:0] f, input logic [1:0] a, input logic v, input logic r);
        @(posedge CLK);
        #1;
        Funct = f; ALUOp = a; InstrValid = v; RST = r;
        model_step(f, a, v, r);
        @(negedge CLK);
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && (busy_left > 0 || hw_due); i++) cycle(F_ADD, 2'b10, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(F_MULT, 2'b10, 1'b1, 1'b1);
            n_checks++;
            if ({MDStart, Stall, HiLoWrite} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_seq cyc %0d got %b want 000", i, {MDStart, Stall, HiLoWrite});
            end
            n_checks++;
            if (ALUControl !== exp_code || IllegalFunct !== exp_ill) begin
                n_fail++;
                $display("FAIL reset_decode got %b/%b want %b/%b", ALUControl, IllegalFunct, exp_code, exp_ill);
            end
        end
        cycle(F_ADD, 2'b10, 1'b1, 1'b0);
        n_checks++;
        if ({MDStart, Stall, HiLoWrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got %b want 000", {MDStart, Stall, HiLoWrite});
        end
    endtask

    task automatic test_decode();
        logic [5:0] f;
        logic [1:0] a;
        logic       v;
        for (int i = 0; i < 9; i++) begin
            cycle(funct_tab[i], 2'b10, 1'b0, 1'b0);
            n_checks++;
            if (ALUControl !== exp_code || IllegalFunct !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_funct %b got %b/%b want %b/0", funct_tab[i], ALUControl, IllegalFunct, exp_code);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) continue;
            a = 2'(i);
            cycle(6'($urandom), a, 1'b1, 1'b0);
            n_checks++;
            if (ALUControl !== exp_code || IllegalFunct !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_aluop %b got %b/%b want %b/0", a, ALUControl, IllegalFunct, exp_code);
            end
        end
        cycle(F_BAD, 2'b10, 1'b1, 1'b0);
        n_checks++;
        if (ALUControl !== 4'b0010 || IllegalFunct !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_illegal got %b/%b want 0010/1", ALUControl, IllegalFunct);
        end
        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(1) == 0) ? funct_tab[$urandom_range(8)] : 6'($urandom);
            a = 2'($urandom);
            v = 1'($urandom);
            cycle(f, a, v, 1'b0);
            n_checks++;
            if (ALUControl !== exp_code || IllegalFunct !== exp_ill) begin
                n_fail++;
                $display("FAIL decode_rand f=%b a=%b v=%b got %b/%b want %b/%b",
                         f, a, v, ALUControl, IllegalFunct, exp_code, exp_ill);
            end
        end
        settle();
    endtask

    // Runs a held MULT or DIV (plus optional follow-on op) and counts the sequencing pulses.
    task automatic run_ops(input string name, input logic [5:0] f0, input int n0,
                           input logic [5:0] f1, input int n1,
                           input int want_stall, input int want_start, input int want_hw);
        int stalls = 0, starts = 0, hws = 0;
        for (int k = 0; k < n0 + n1 + 2; k++) begin
            cycle((k < n0) ? f0 : (k < n0 + n1) ? f1 : F_ADD, 2'b10, 1'b1, 1'b0);
            stalls += int'(Stall);
            starts += int'(MDStart);
            hws    += int'(HiLoWrite);
            n_checks++;
            if ({MDStart, Stall, HiLoWrite} !== {exp_start, exp_stall, exp_hw}) begin
                n_fail++;
                $display("FAIL %s seq cyc %0d got %b want %b", name, k,
                         {MDStart, Stall, HiLoWrite}, {exp_start, exp_stall, exp_hw});
            end
            if (exp_start || exp_stall || exp_hw) begin
                n_checks++;
                if (MDOp !== exp_op) begin
                    n_fail++;
                    $display("FAIL %s mdop cyc %0d got %b want %b", name, k, MDOp, exp_op);
                end
            end
        end
        n_checks++;
        if (stalls != want_stall || starts != want_start || hws != want_hw) begin
            n_fail++;
            $display("FAIL %s counts stall/start/hw got %0d/%0d/%0d want %0d/%0d/%0d",
                     name, stalls, starts, hws, want_stall, want_start, want_hw);
        end
    endtask

    task automatic test_mult();
        run_ops("mult", F_MULT, MUL_LAT + 2, F_ADD, 0, MUL_LAT + 1, 1, 1);
    endtask

    task automatic test_div();
        run_ops("div", F_DIV, DIV_LAT + 2, F_ADD, 0, DIV_LAT + 1, 1, 1);
    endtask

    task automatic test_back_to_back();
        run_ops("b2b", F_MULT, MUL_LAT + 2, F_DIV, DIV_LAT + 2, MUL_LAT + DIV_LAT + 2, 2, 2);
    endtask

    task automatic test_reset_mid();
        int hws = 0, stalls = 0;
        cycle(F_MULT, 2'b10, 1'b1, 1'b0);
        cycle(F_MULT, 2'b10, 1'b1, 1'b0);
        cycle(F_MULT, 2'b10, 1'b1, 1'b1);
        n_checks++;
        if ({MDStart, Stall, HiLoWrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_abort got %b want 000", {MDStart, Stall, HiLoWrite});
        end
        for (int k = 0; k < 8; k++) begin
            cycle(F_ADD, 2'b10, 1'b1, 1'b0);
            hws    += int'(HiLoWrite);
            stalls += int'(Stall);
        end
        n_checks++;
        if (hws != 0 || stalls != 0) begin
            n_fail++;
            $display("FAIL rstmid_after hw/stall got %0d/%0d want 0/0", hws, stalls);
        end
        run_ops("rstmid_new", F_MULT, MUL_LAT + 2, F_ADD, 0, MUL_LAT + 1, 1, 1);
    endtask

    task automatic test_bubble();
        for (int k = 0; k < 3; k++) begin
            cycle(F_MULT, 2'b10, 1'b0, 1'b0);
            n_checks++;
            if ({MDStart, Stall, IllegalFunct} !== 3'b000 || ALUControl !== 4'b0011) begin
                n_fail++;
                $display("FAIL bubble got start/stall/ill %b ctrl %b want 000 ctrl 0011",
                         {MDStart, Stall, IllegalFunct}, ALUControl);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] f;
        logic [1:0] a;
        logic       v, r;
        int         sel;
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(7));
            f = (sel < 2) ? F_MULT : (sel == 2) ? F_DIV :
                (sel < 6) ? funct_tab[$urandom_range(8)] : 6'($urandom);
            a = ($urandom_range(3) != 0) ? 2'b10 : 2'($urandom);
            v = ($urandom_range(7) != 0);
            r = ($urandom_range(49) == 0);
            cycle(f, a, v, r);
            n_checks++;
            if ({MDStart, Stall, HiLoWrite, ALUControl, IllegalFunct} !==
                {exp_start, exp_stall, exp_hw, exp_code, exp_ill}) begin
                n_fail++;
                $display("FAIL random cyc %0d got %b_%b_%b want %b_%b_%b", k,
                         {MDStart, Stall, HiLoWrite}, ALUControl, IllegalFunct,
                         {exp_start, exp_stall, exp_hw}, exp_code, exp_ill);
            end
            if (exp_start || exp_stall || exp_hw) begin
                n_checks++;
                if (MDOp !== exp_op) begin
                    n_fail++;
                    $display("FAIL random mdop cyc %0d got %b want %b", k, MDOp, exp_op);
                end
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decoder_mc.md
Name: alu_decoder_mc

Overview:
Parametrised successor ALU decoder for the MIPS core.
- Extends the single-cycle Funct/ALUOp decode to a 4-bit control code with AND/OR/NOR.
- Adds sequencing for multi-cycle MULT/DIV: issues a start pulse to the external mul/div unit, stalls the PC/pipeline for a programmable latency, then asserts HI/LO write for one cycle.
- Sits between the main control decoder and the ALU / mul-div datapath.

Parameters:
Funct_size, 6, width of Funct field
Ctrl_size, 4, width of ALUControl (must be >= 4)
MulLatency, 4, busy cycles for MULT (>= 1)
DivLatency, 32, busy cycles for DIV (>= 1)
Cnt_size, 6, latency counter width; must satisfy 2^Cnt_size > max(MulLatency, DivLatency)

Ports:
CLK  input  1  single clock, all state on rising edge
RST  input  1  synchronous reset, active-high
Funct  input  Funct_size  R-type function field
ALUOp  input  2  from main decoder
InstrValid  input  1  current instruction is valid (not a bubble)
ALUControl  output  Ctrl_size  ALU operation code
IllegalFunct  output  1  unrecognised Funct with ALUOp=10
MDStart  output  1  one-cycle start pulse to mul/div unit
MDOp  output  1  0=MULT, 1=DIV; valid with MDStart, held until DONE ends
Stall  output  1  freeze PC/pipeline
HiLoWrite  output  1  one-cycle HI/LO register write enable

Behaviour:
- ALUControl is combinational from ALUOp/Funct in every state:
  - ALUOp=00 -> 0010 (ADD); 01 -> 0100 (SUB); 11 -> 0010.
  - ALUOp=10, Funct decode: 100000 ADD 0010; 100010 SUB 0100; 100100 AND 0000; 100101 OR 0001; 100111 NOR 1000; 101010 SLT 0110; 011100 MUL 0101 (single-cycle); 011000 MULT 0011; 011010 DIV 0111.
  - Any other Funct -> 0010, and IllegalFunct = InstrValid.
- IllegalFunct = 0 whenever ALUOp != 10.
- Legacy 3-bit codes (010/100/110/101) are preserved as zero-extended values.
- Start condition: state IDLE, InstrValid=1, ALUOp=10, Funct is MULT or DIV.
- FSM states are IDLE, BUSY, DONE.
  - IDLE: on start, MDStart=1 and Stall=1 (both combinational, same cycle); MDOp register <= (Funct==DIV); cnt <= latency-1; next state BUSY. Otherwise all sequencing outputs are 0.
  - BUSY: Stall=1, MDStart=0. If cnt==0, next state DONE; else cnt <= cnt-1. BUSY lasts exactly latency cycles.
  - DONE: Stall=0, HiLoWrite=1 for exactly one cycle, next state IDLE. The start condition is ignored in DONE, because the stalled MULT/DIV is still presented and must not reissue.
- Total Stall cycles per MULT/DIV = latency+1, followed by one HiLoWrite cycle.
- Back-to-back MULT/DIV: a new start is accepted in the IDLE cycle immediately after DONE.
- While Stall=1, Funct/ALUOp changes do not affect the FSM; the latched MDOp and cnt govern.
- InstrValid=0 in IDLE: no start, even if Funct is MULT/DIV.
- Reset:
  - Register values: state=IDLE, cnt=0, MDOp=0.
  - While RST=1: MDStart=0, Stall=0, HiLoWrite=0, and the start condition is blocked.
  - RST in BUSY or DONE aborts: no HiLoWrite is issued, and the next cycle after RST falls is IDLE.
- ALUControl and IllegalFunct are unaffected by RST; they are purely combinational.

Test Plan:
- Decode sweep: ALUOp=10 with each listed Funct -> listed ALUControl, IllegalFunct=0. ALUOp=00/01/11 -> 0010/0100/0010. Funct=111111, ALUOp=10, InstrValid=1 -> 0010, IllegalFunct=1.
- MULT, MulLatency=4: cycle0 start -> MDStart=1, MDOp=0, Stall=1. Stall=1 through cycles 0-4. Cycle5: Stall=0, HiLoWrite=1. Cycle6: HiLoWrite=0, state IDLE.
- DIV, DivLatency=32: Stall high for exactly 33 cycles, MDOp=1 throughout, a single HiLoWrite pulse. MULT/DIV held on the inputs during DONE -> no second MDStart.
- Back-to-back: MULT then DIV presented in the cycle after DONE -> second MDStart in that cycle; total Stall = 5 + 33 with one zero-stall DONE cycle between.
- Reset mid-op: RST=1 at BUSY cycle 2 of a MULT -> Stall=0 in that cycle, no HiLoWrite ever. After release, IDLE; a new MULT is accepted normally.
- Bubble: InstrValid=0 with Funct=011000, ALUOp=10 -> MDStart=0, Stall=0, IllegalFunct=0.
